// File: rtl/uart_tx_word_sender_pkg.sv
// Shared widths and FSM encodings for the UART word sender, transmitter and debug unit.
package uart_tx_word_sender_pkg;

  localparam int unsigned N_DATA   = 8;
  localparam int unsigned N_BYTES  = 4;
  localparam int unsigned NB_WORD  = N_DATA * N_BYTES;
  localparam int unsigned NB_STATE = 3;

  // One-hot sender states.
  typedef enum logic [NB_STATE-1:0] {
    StIdle = 3'b001,
    StSend = 3'b010,
    StWait = 3'b100
  } state_e;

endpackage

// File: rtl/uart_tx_word_sender_if.sv
// Word handshake between the debug/control unit (master) and the word sender (slave).
interface uart_tx_word_sender_if #(
  parameter int unsigned NB_WORD = uart_tx_word_sender_pkg::NB_WORD
);

  logic [NB_WORD-1:0] word_in;
  logic               word_valid;
  logic               word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/tx_word_fifo.sv
// Synchronous word FIFO; dout is the head entry and is valid while not empty.
module tx_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = uart_tx_word_sender_pkg::NB_WORD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_word_sender.sv
// Splits queued 32-bit words into bytes (LSB first) and paces them into the UART transmitter.
module uart_tx_word_sender #(
  parameter int unsigned N_DATA     = uart_tx_word_sender_pkg::N_DATA,
  parameter int unsigned N_BYTES    = uart_tx_word_sender_pkg::N_BYTES,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NB_STATE   = uart_tx_word_sender_pkg::NB_STATE
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_tx_word_sender_if.slave        word_bus,
  input  logic                        tx_done_tick,
  output logic                        tx_start,
  output logic [N_DATA-1:0]           tx_data,
  output logic                        busy
);

  import uart_tx_word_sender_pkg::*;

  localparam int unsigned NB_W   = N_DATA * N_BYTES;
  localparam int unsigned NB_CNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [NB_STATE-1:0] state_q, state_d;
  logic [NB_W-1:0]     word_q, word_d;
  logic [NB_CNT-1:0]   byte_cnt_q, byte_cnt_d;

  logic            fifo_pop, fifo_full, fifo_empty, fifo_push;
  logic [NB_W-1:0] fifo_dout;

  assign word_bus.word_ready = !fifo_full;
  assign fifo_push           = word_bus.word_valid && !fifo_full;

  tx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NB_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (word_bus.word_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs decode from registers only.
  assign tx_start = (state_q == StSend);
  assign tx_data  = word_q[N_DATA-1:0];
  assign busy     = !fifo_empty || (state_q != StIdle);

  // State, shift register and byte counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next-state logic; done ticks only count while waiting on a byte.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          word_d     = fifo_dout;
          fifo_pop   = 1'b1;
          byte_cnt_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        state_d = StWait;
      end
      StWait: begin
        if (tx_done_tick) begin
          if (byte_cnt_q == NB_CNT'(N_BYTES - 1)) begin
            state_d = StIdle;
          end else begin
            word_d     = word_q >> N_DATA;
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = StSend;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule
